// File: rtl/echo_share_arbiter_if.sv
// Handshake bundle between the requester ports, the arbiter and the shared echo unit.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface echo_share_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int MSG_NBITS = 11
);
    logic [NREQ-1:0]           req_in_val;
    logic [NREQ-1:0]           req_in_rdy;
    logic [NREQ*MSG_NBITS-1:0] req_in_msg;
    logic [NREQ-1:0]           req_out_val;
    logic [NREQ-1:0]           req_out_rdy;
    logic [NREQ*MSG_NBITS-1:0] req_out_msg;
    logic                      unit_send_val;
    logic                      unit_send_rdy;
    logic [MSG_NBITS-1:0]      unit_send_msg;
    logic                      unit_recv_val;
    logic                      unit_recv_rdy;
    logic [MSG_NBITS-1:0]      unit_recv_msg;

    modport slave (
        input  req_in_val, req_in_msg, req_out_rdy,
        input  unit_send_rdy, unit_recv_val, unit_recv_msg,
        output req_in_rdy, req_out_val, req_out_msg,
        output unit_send_val, unit_send_msg, unit_recv_rdy
    );

    modport master (
        output req_in_val, req_in_msg, req_out_rdy,
        output unit_send_rdy, unit_recv_val, unit_recv_msg,
        input  req_in_rdy, req_out_val, req_out_msg,
        input  unit_send_val, unit_send_msg, unit_recv_rdy
    );
endinterface

// File: rtl/echo_share_arbiter.sv
// Round-robin sharing of one in-order echo unit among NREQ requesters, with a tag FIFO routing
// responses back. Define ECHO_SHARE_ARBITER_STATS_EN for per-requester issue and stall counters.
module echo_share_arbiter #(
    parameter int NREQ      = 4,
    parameter int MSG_NBITS = 11,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    echo_share_arbiter_if.slave  bus
`ifdef ECHO_SHARE_ARBITER_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_issue_cnt,
    output logic [15:0]          stat_stall_cnt
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        occ_q, occ_d;
    logic [PW-1:0]        tag_mem_q [TAG_DEPTH];
    logic [MSG_NBITS-1:0] in_msg [NREQ];

    logic [PW-1:0] grant;
    logic [PW:0]   scan_sum;
    logic          any_cand;
    logic          tag_full, tag_empty;
    logic [PW-1:0] tag_head;
    logic          issue_fire, recv_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slices
            assign in_msg[gi] = bus.req_in_msg[gi*MSG_NBITS +: MSG_NBITS];
            assign bus.req_out_msg[gi*MSG_NBITS +: MSG_NBITS] = bus.unit_recv_msg;
        end
    endgenerate

    // Scan offsets from the far end down so the nearest candidate to rr_ptr wins.
    always_comb begin
        grant    = '0;
        any_cand = 1'b0;
        scan_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ))
                scan_sum = scan_sum - (PW+1)'(NREQ);
            if (bus.req_in_val[scan_sum[PW-1:0]]) begin
                grant    = scan_sum[PW-1:0];
                any_cand = 1'b1;
            end
        end
    end

    assign tag_full  = (occ_q == CW'(TAG_DEPTH));
    assign tag_empty = (occ_q == '0);
    assign tag_head  = tag_mem_q[rd_ptr_q];

    assign bus.unit_send_val = reset & any_cand & ~tag_full;
    assign bus.unit_send_msg = any_cand ? in_msg[grant] : '0;
    assign bus.unit_recv_rdy = reset & ~tag_empty & bus.req_out_rdy[tag_head];

    always_comb begin
        bus.req_in_rdy  = '0;
        bus.req_out_val = '0;
        if (reset & any_cand & bus.unit_send_rdy & ~tag_full)
            bus.req_in_rdy[grant] = 1'b1;
        if (reset & bus.unit_recv_val & ~tag_empty)
            bus.req_out_val[tag_head] = 1'b1;
    end

    assign issue_fire = bus.unit_send_val & bus.unit_send_rdy;
    assign recv_fire  = bus.unit_recv_val & bus.unit_recv_rdy;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue_fire)
            rr_ptr_d = (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
        occ_d = occ_q;
        if (issue_fire && !recv_fire)
            occ_d = occ_q + 1'b1;
        else if (!issue_fire && recv_fire)
            occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            occ_q    <= occ_d;
            if (issue_fire)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (recv_fire)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Tag storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (issue_fire)
            tag_mem_q[wr_ptr_q] <= grant;
    end

`ifdef ECHO_SHARE_ARBITER_STATS_EN
    logic [15:0] issue_cnt_q [NREQ];
    logic [15:0] stall_cnt_q;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stats
            always_ff @(posedge clk) begin
                if (!reset)
                    issue_cnt_q[gi] <= '0;
                else if (issue_fire && grant == PW'(gi) && issue_cnt_q[gi] != 16'hFFFF)
                    issue_cnt_q[gi] <= issue_cnt_q[gi] + 16'd1;
            end
            assign stat_issue_cnt[gi*16 +: 16] = issue_cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (any_cand && !issue_fire && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end
    assign stat_stall_cnt = stall_cnt_q;
`endif
endmodule
